// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback port arbiter bus: pipe/long-latency requests, RF write port, interlock query
interface wb_port_arbiter_if;
   logic [3:0]  pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic [3:0]  we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  rd1addr;
   logic [4:0]  rd2addr;
   logic        pend_haz;
   logic        stall_req;

   modport master (
      output pipe_we, pipe_waddr, pipe_wdata,
      output lu_valid, lu_waddr, lu_wdata,
      input  lu_ready,
      input  we, waddr, wdata,
      output rd1addr, rd2addr,
      input  pend_haz, stall_req
   );

   modport slave (
      input  pipe_we, pipe_waddr, pipe_wdata,
      input  lu_valid, lu_waddr, lu_wdata,
      output lu_ready,
      output we, waddr, wdata,
      input  rd1addr, rd2addr,
      output pend_haz, stall_req
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter with 2-entry long-latency result buffer (option: WB_STARVE_GUARD_EN)
module wb_port_arbiter #(
   parameter int WAIT_LIMIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   wb_port_arbiter_if.slave bus
);

   // Entry 0 is always the head; entry 1 is only valid when entry 0 is.
   logic [1:0]  v_q,  v_d;
   logic [4:0]  a_q  [2];
   logic [4:0]  a_d  [2];
   logic [31:0] d_q  [2];
   logic [31:0] d_d  [2];

   logic       pipe_wr;
   logic       pipe_full;
   logic       lu_ready_i;
   logic       push;
   logic       pop;
   logic [1:0] inval;
   logic [1:0] keep;

   // Next buffer contents: remove popped/overwritten entries, compact, then append the new result.
   always_comb begin
      pipe_wr    = |bus.pipe_we;
      pipe_full  = (bus.pipe_we == 4'hF);
      lu_ready_i = rst & ~v_q[1];
      push       = bus.lu_valid & lu_ready_i & (bus.lu_waddr != 5'd0);
      pop        = ~pipe_wr & v_q[0];
      for (int i = 0; i < 2; i++) begin
         inval[i] = pipe_full & v_q[i] & (a_q[i] == bus.pipe_waddr);
      end
      keep[0] = v_q[0] & ~inval[0] & ~pop;
      keep[1] = v_q[1] & ~inval[1];

      v_d = 2'b00;
      a_d = a_q;
      d_d = d_q;
      case (keep)
         2'b11:   v_d = 2'b11;
         2'b01:   v_d = 2'b01;
         2'b10: begin
            v_d    = 2'b01;
            a_d[0] = a_q[1];
            d_d[0] = d_q[1];
         end
         default: v_d = 2'b00;
      endcase

      if (push) begin
         if (v_d[0]) begin
            v_d[1] = 1'b1;
            a_d[1] = bus.lu_waddr;
            d_d[1] = bus.lu_wdata;
         end else begin
            v_d[0] = 1'b1;
            a_d[0] = bus.lu_waddr;
            d_d[0] = bus.lu_wdata;
         end
      end
   end

   // Buffer state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            a_q[i] <= 5'd0;
            d_q[i] <= 32'd0;
         end
      end else begin
         v_q <= v_d;
         a_q <= a_d;
         d_q <= d_d;
      end
   end

   // Write port mux (pipeline has priority) and read-after-write interlock query.
   always_comb begin
      bus.we       = 4'h0;
      bus.waddr    = 5'd0;
      bus.wdata    = 32'd0;
      bus.pend_haz = 1'b0;
      if (rst) begin
         if (pipe_wr) begin
            bus.we    = bus.pipe_we;
            bus.waddr = bus.pipe_waddr;
            bus.wdata = bus.pipe_wdata;
         end else if (v_q[0]) begin
            bus.we    = 4'hF;
            bus.waddr = a_q[0];
            bus.wdata = d_q[0];
         end
         for (int i = 0; i < 2; i++) begin
            if (v_q[i] && (((bus.rd1addr != 5'd0) && (bus.rd1addr == a_q[i])) ||
                           ((bus.rd2addr != 5'd0) && (bus.rd2addr == a_q[i])))) begin
               bus.pend_haz = 1'b1;
            end
         end
      end
   end

   assign bus.lu_ready = lu_ready_i;

`ifdef WB_STARVE_GUARD_EN
   localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);
   logic [7:0] wait_q;

   // Count cycles the head is held off by pipeline writes; saturates so stall_req stays up until it drains.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q <= 8'd0;
      end else if (pop || !v_q[0]) begin
         wait_q <= 8'd0;
      end else if (pipe_wr && (wait_q != LIMIT)) begin
         wait_q <= wait_q + 8'd1;
      end
   end

   assign bus.stall_req = rst & v_q[0] & (wait_q == LIMIT);
`else
   // No starvation guard: legal WAIT_LIMIT is never 0, so stall is never requested.
   assign bus.stall_req = rst & (WAIT_LIMIT == 0);
`endif

endmodule
